// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain
// Read-side consumer for the async FIFO. All logic runs in the read clock
// domain. It pops words from the FIFO read port and presents them downstream
// as a valid/ready stream through a 2-entry register buffer. The block also
// provides enable and flush (discard) control and two wrapping counters.
//
// Ports:
//   rd_clk     read-domain clock; all state changes on its rising edge
//   rd_rst     synchronous, active-high reset
//   en         level; permits popping from the FIFO
//   flush      level; discards buffered words and drains the FIFO
//   rd_empty   FIFO empty flag
//   rd_data    FIFO head word; valid in the same cycle whenever rd_empty=0
//   rd_inc     FIFO pop strobe, at most one word per cycle
//   out_data   downstream data (head of the output buffer)
//   out_valid  downstream valid
//   out_ready  downstream ready
//   pop_count  words handed downstream (wraps)
//   drop_count words discarded by flush (wraps)
//   busy       high while not IDLE or while the buffer still holds words
module fifo_rd_drain #(
    parameter int DATA_SIZE = 8,
    parameter int CNT_W     = 16
) (
    input  logic                 rd_clk,
    input  logic                 rd_rst,
    input  logic                 en,
    input  logic                 flush,
    input  logic                 rd_empty,
    input  logic [DATA_SIZE-1:0] rd_data,
    output logic                 rd_inc,
    output logic [DATA_SIZE-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CNT_W-1:0]     pop_count,
    output logic [CNT_W-1:0]     drop_count,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t               state;
    logic [1:0]           count;
    logic [DATA_SIZE-1:0] head_word;
    logic [DATA_SIZE-1:0] tail_word;
    logic                 handshake;
    logic                 push;

    // The pop strobe looks only at registered state, registered count and the
    // empty flag, so downstream ready can never ripple back into the FIFO.
    always_comb begin
        rd_inc = 1'b0;
        if (!rd_rst && !rd_empty) begin
            case (state)
                RUN:     rd_inc = (count != 2'd2);
                FLUSH:   rd_inc = 1'b1;
                default: rd_inc = 1'b0;
            endcase
        end
    end

    assign out_valid = (count != 2'd0);
    assign out_data  = head_word;
    assign handshake = out_valid && out_ready;
    assign push      = rd_inc && (state == RUN);
    assign busy      = (state != IDLE) || (count != 2'd0);

    // Flush wins over everything: on the entry edge the buffer is emptied and
    // its occupancy is charged to drop_count, and no handshake completes.
    // A word popped from the FIFO on that same edge is discarded with the
    // buffer. Outside flush, pop-before-push ordering keeps the head moving
    // so that count=1 sustains one word per cycle.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state      <= IDLE;
            count      <= 2'd0;
            head_word  <= '0;
            tail_word  <= '0;
            pop_count  <= '0;
            drop_count <= '0;
        end else begin
            case (state)
                IDLE, RUN: begin
                    if (flush) begin
                        drop_count <= drop_count + CNT_W'(count);
                        count      <= 2'd0;
                        state      <= FLUSH;
                    end else begin
                        if (handshake && push) begin
                            // Only reachable at count=1: replace the head in place.
                            head_word <= rd_data;
                        end else if (handshake) begin
                            head_word <= tail_word;
                            count     <= count - 2'd1;
                        end else if (push) begin
                            if (count == 2'd0) begin
                                head_word <= rd_data;
                            end else begin
                                tail_word <= rd_data;
                            end
                            count <= count + 2'd1;
                        end

                        if (handshake) begin
                            pop_count <= pop_count + CNT_W'(1);
                        end

                        if (state == IDLE && en) begin
                            state <= RUN;
                        end else if (state == RUN && !en) begin
                            state <= IDLE;
                        end
                    end
                end

                FLUSH: begin
                    if (rd_inc) begin
                        drop_count <= drop_count + CNT_W'(1);
                    end
                    if (!flush && rd_empty) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                    count <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Testbench for fifo_rd_drain. A queue stands in for the async FIFO, and a
// queue-based reference model of the drain block predicts every output.
// Directed scenarios are followed by a randomized run. CNT_W is set to 4 so
// that counter wrap is reachable.
module tb_fifo_rd_drain;

    localparam int DW  = 8;
    localparam int CW  = 4;
    localparam int CNT_MASK = (1 << CW) - 1;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_FLUSH = 2;

    logic          rd_clk = 1'b0;
    logic          rd_rst;
    logic          en;
    logic          flush;
    logic          rd_empty;
    logic [DW-1:0] rd_data;
    logic          rd_inc;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] pop_count;
    logic [CW-1:0] drop_count;
    logic          busy;

    fifo_rd_drain #(.DATA_SIZE(DW), .CNT_W(CW)) dut (
        .rd_clk     (rd_clk),
        .rd_rst     (rd_rst),
        .en         (en),
        .flush      (flush),
        .rd_empty   (rd_empty),
        .rd_data    (rd_data),
        .rd_inc     (rd_inc),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .pop_count  (pop_count),
        .drop_count (drop_count),
        .busy       (busy)
    );

    always #5 rd_clk = ~rd_clk;

    // Source FIFO contents, reference model state and bookkeeping.
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] m_buf[$];
    logic [DW-1:0] seen[$];
    int            m_mode;
    int            m_pop;
    int            m_drop;
    int            checks;
    int            errors;
    int            inc_cycles;
    bit            armed;

    task automatic refreshFifo();
        rd_empty = (fifo_q.size() == 0);
        rd_data  = rd_empty ? '0 : fifo_q[0];
    endtask

    task automatic pushWord(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        refreshFifo();
    endtask

    function automatic bit modelRdInc();
        if (rd_rst || rd_empty) return 1'b0;
        if (m_mode == M_RUN)   return (m_buf.size() < 2);
        if (m_mode == M_FLUSH) return 1'b1;
        return 1'b0;
    endfunction

    // One clock edge of the block, written straight from its rules.
    task automatic modelStep();
        bit inc;
        bit hs;
        inc = modelRdInc();
        hs  = (m_buf.size() != 0) && out_ready;
        if (rd_rst) begin
            m_mode = M_IDLE;
            m_buf.delete();
            m_pop  = 0;
            m_drop = 0;
        end else if (m_mode == M_FLUSH) begin
            if (inc) m_drop = (m_drop + 1) & CNT_MASK;
            if (!flush && rd_empty) m_mode = M_IDLE;
        end else if (flush) begin
            m_drop = (m_drop + m_buf.size()) & CNT_MASK;
            m_buf.delete();
            m_mode = M_FLUSH;
        end else begin
            if (hs) begin
                void'(m_buf.pop_front());
                m_pop = (m_pop + 1) & CNT_MASK;
            end
            if (inc) m_buf.push_back(rd_data);
            if (m_mode == M_IDLE && en) m_mode = M_RUN;
            else if (m_mode == M_RUN && !en) m_mode = M_IDLE;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compareModel();
        checkOutput("rd_inc", {31'd0, rd_inc}, {31'd0, modelRdInc()});
        checkOutput("no_underflow", {31'd0, rd_inc & rd_empty}, 32'd0);
        checkOutput("out_valid", {31'd0, out_valid}, {31'd0, m_buf.size() != 0});
        if (m_buf.size() != 0) checkOutput("out_data", {24'd0, out_data}, {24'd0, m_buf[0]});
        checkOutput("pop_count", {28'd0, pop_count}, m_pop);
        checkOutput("drop_count", {28'd0, drop_count}, m_drop);
        checkOutput("busy", {31'd0, busy}, {31'd0, (m_mode != M_IDLE) || (m_buf.size() != 0)});
    endtask

    // Advance one cycle: entered and left at negedge+1 with inputs stable.
    task automatic tick();
        bit pop_now;
        bit hs_now;
        logic [DW-1:0] d_now;
        #3;
        pop_now = (rd_inc === 1'b1);
        hs_now  = (out_valid === 1'b1) && (out_ready === 1'b1) && !flush;
        d_now   = out_data;
        @(posedge rd_clk);
        #1;
        modelStep();
        if (pop_now) begin
            inc_cycles++;
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
        end
        if (hs_now && !rd_rst) seen.push_back(d_now);
        refreshFifo();
        @(negedge rd_clk);
        if (armed) compareModel();
        #1;
    endtask

    task automatic doReset();
        rd_rst    = 1'b1;
        en        = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        fifo_q.delete();
        refreshFifo();
        tick();
        armed = 1'b1;
        tick();
        rd_rst = 1'b0;
        seen.delete();
        inc_cycles = 0;
    endtask

    task automatic applyStimulus();
        rd_rst    = ($urandom_range(0, 149) == 0);
        en        = ($urandom_range(0, 9) != 0);
        flush     = ($urandom_range(0, 24) == 0);
        out_ready = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 1) == 1 && fifo_q.size() < 12) pushWord(8'($urandom));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        armed  = 1'b0;
        m_mode = M_IDLE;
        m_pop  = 0;
        m_drop = 0;
        rd_rst = 1'b1;
        en = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        refreshFifo();
        @(negedge rd_clk);
        #1;

        // Reset state
        doReset();
        checkOutput("reset_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_data", {24'd0, out_data}, 32'd0);
        checkOutput("reset_pop", {28'd0, pop_count}, 32'd0);
        checkOutput("reset_drop", {28'd0, drop_count}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);

        // Streaming three preloaded words
        pushWord(8'h11); pushWord(8'h22); pushWord(8'h33);
        en = 1'b1; out_ready = 1'b1;
        repeat (7) tick();
        checkOutput("stream_inc_cycles", inc_cycles, 32'd3);
        checkOutput("stream_seen_n", seen.size(), 32'd3);
        if (seen.size() == 3) begin
            checkOutput("stream_w0", {24'd0, seen[0]}, 32'h11);
            checkOutput("stream_w1", {24'd0, seen[1]}, 32'h22);
            checkOutput("stream_w2", {24'd0, seen[2]}, 32'h33);
        end
        checkOutput("stream_pop", {28'd0, pop_count}, 32'd3);

        // Backpressure
        doReset();
        for (int i = 0; i < 5; i++) pushWord(8'(8'hA0 + i));
        en = 1'b1; out_ready = 1'b0;
        repeat (5) tick();
        checkOutput("bp_inc_cycles", inc_cycles, 32'd2);
        checkOutput("bp_hold_data", {24'd0, out_data}, 32'hA0);
        checkOutput("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        repeat (8) tick();
        checkOutput("bp_seen_n", seen.size(), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < seen.size()) checkOutput("bp_order", {24'd0, seen[i]}, 32'hA0 + i);
        checkOutput("bp_pop", {28'd0, pop_count}, 32'd5);

        // Flush with a full buffer and four words left in the FIFO
        doReset();
        for (int i = 0; i < 6; i++) pushWord(8'(8'hB0 + i));
        en = 1'b1; out_ready = 1'b0;
        repeat (4) tick();
        flush = 1'b1; en = 1'b0;
        tick();
        flush = 1'b0;
        checkOutput("flush_valid_off", {31'd0, out_valid}, 32'd0);
        checkOutput("flush_drop_entry", {28'd0, drop_count}, 32'd2);
        repeat (6) tick();
        checkOutput("flush_drop_total", {28'd0, drop_count}, 32'd6);
        checkOutput("flush_pop", {28'd0, pop_count}, 32'd0);
        checkOutput("flush_idle", {31'd0, busy}, 32'd0);

        // en dropped mid-stream with a full buffer
        doReset();
        for (int i = 0; i < 4; i++) pushWord(8'(8'hC0 + i));
        en = 1'b1; out_ready = 1'b0;
        repeat (4) tick();
        en = 1'b0;
        inc_cycles = 0;
        repeat (2) tick();
        out_ready = 1'b1;
        tick();
        checkOutput("endrop_busy_mid", {31'd0, busy}, 32'd1);
        tick();
        checkOutput("endrop_busy_done", {31'd0, busy}, 32'd0);
        checkOutput("endrop_pop", {28'd0, pop_count}, 32'd2);
        checkOutput("endrop_no_inc", inc_cycles, 32'd0);

        // Reset while one word is buffered and the FIFO is non-empty
        doReset();
        for (int i = 0; i < 3; i++) pushWord(8'(8'hD0 + i));
        en = 1'b1; out_ready = 1'b0;
        repeat (2) tick();
        checkOutput("rst_pre_valid", {31'd0, out_valid}, 32'd1);
        rd_rst = 1'b1; en = 1'b0;
        tick();
        checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_pop", {28'd0, pop_count}, 32'd0);
        checkOutput("rst_inc", {31'd0, rd_inc}, 32'd0);
        rd_rst = 1'b0;
        tick();
        checkOutput("rst_idle_inc", {31'd0, rd_inc}, 32'd0);
        checkOutput("rst_idle_busy", {31'd0, busy}, 32'd0);

        // Counter wrap: 17 words through a 4-bit counter
        doReset();
        for (int i = 0; i < 17; i++) pushWord(8'(i + 1));
        en = 1'b1; out_ready = 1'b1;
        repeat (22) tick();
        checkOutput("wrap_seen_n", seen.size(), 32'd17);
        checkOutput("wrap_pop", {28'd0, pop_count}, 32'd1);

        // Randomized run against the model
        doReset();
        repeat (1500) begin
            applyStimulus();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard bound on run time in case the stimulus process ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL timeout got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
